function_sweeper: RTL and testbench

Sequential stimulus-and-capture stage that sits directly upstream of the 5-input combinational function block. On a start pulse it drives every input code 0..2^N_IN-1 onto the function's `x` bus, one code per clock. It samples the returned `y` each cycle into a truth-table register and counts the minterms. It then compares the captured table against an expected table and reports the first mismatching row.

---
 rtl/function_sweeper_pkg.sv | 14 +
 rtl/function_sweeper_if.sv | 48 ++++
 rtl/sweep_counter.sv | 24 ++
 rtl/function_sweeper.sv | 92 +++++++++
 tb/tb_function_sweeper.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/function_sweeper_pkg.sv
// Shared types and defaults for the function sweeper.
// State encoding and default sizing.
package sweeper_pkg;

  localparam int N_IN_DEFAULT = 5;
  localparam int ROWS_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

endpackage

// File: rtl/function_sweeper_if.sv
// Sweeper bus: control, results and the
// x/y link to the function under test.
interface function_sweeper_if
  import sweeper_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
);

  localparam int ROWS = 1 << N_IN;

  logic            start;
  logic [ROWS-1:0] expected;
  logic [N_IN-1:0] x;
  logic            y;
  logic            busy;
  logic            done;
  logic [ROWS-1:0] truth;
  logic [N_IN:0]   ones;
  logic            mismatch;
  logic [N_IN-1:0] first_err;

  modport master (
    output start,
    output expected,
    output y,
    input  x,
    input  busy,
    input  done,
    input  truth,
    input  ones,
    input  mismatch,
    input  first_err
  );

  modport slave (
    input  start,
    input  expected,
    input  y,
    output x,
    output busy,
    output done,
    output truth,
    output ones,
    output mismatch,
    output first_err
  );

endinterface

// File: rtl/sweep_counter.sv
// Row index counter: clear, enable and
// terminal count; saturates at the last row.
module sweep_counter #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] q,
  output logic         tc
);

  assign tc = (q == {N{1'b1}});

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en && !tc) begin
      q <= q + N'(1);
    end
  end

endmodule

// File: rtl/function_sweeper.sv
// Drives every input code into a combinational
// function, captures its truth table and checks it.
module function_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  function_sweeper_if.slave bus
);

  localparam int ROWS = 1 << N_IN;

  state_t          state;
  state_t          state_n;
  logic [N_IN-1:0] idx;
  logic            tc;
  logic            go;
  logic            sweeping;

  logic [ROWS-1:0] exp_q;
  logic [ROWS-1:0] truth_q;
  logic [N_IN:0]   ones_q;
  logic            mis_q;
  logic [N_IN-1:0] ferr_q;

  assign sweeping = (state == SWEEP);
  assign go       = bus.start && !sweeping;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE,
      DONE:    if (bus.start) state_n = SWEEP;
      SWEEP:   if (tc) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  sweep_counter #(
    .N (N_IN)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (go),
    .en  (sweeping),
    .q   (idx),
    .tc  (tc)
  );

  // Only the first differing row is kept; mis_q gates later rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q   <= '0;
      truth_q <= '0;
      ones_q  <= '0;
      mis_q   <= 1'b0;
      ferr_q  <= '0;
    end else if (go) begin
      exp_q   <= bus.expected;
      truth_q <= '0;
      ones_q  <= '0;
      mis_q   <= 1'b0;
      ferr_q  <= '0;
    end else if (sweeping) begin
      truth_q[idx] <= bus.y;
      ones_q       <= ones_q + {{N_IN{1'b0}}, bus.y};
      if ((bus.y != exp_q[idx]) && !mis_q) begin
        mis_q  <= 1'b1;
        ferr_q <= idx;
      end
    end
  end

  assign bus.x         = idx;
  assign bus.busy      = sweeping;
  assign bus.done      = (state == DONE);
  assign bus.truth     = truth_q;
  assign bus.ones      = ones_q;
  assign bus.mismatch  = mis_q;
  assign bus.first_err = ferr_q;

endmodule

// File: tb/tb_function_sweeper.sv
// Randomized self-checking bench for function_sweeper
// against a truth-table reference model.
module tb_function_sweeper;

  import sweeper_pkg::*;

  localparam int N = 5;
  localparam int R = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  function_sweeper_if #(.N_IN(N)) bus ();

  logic [R-1:0] fn_tbl = '0;

  assign bus.y = fn_tbl[bus.x];

  function_sweeper #(
    .N_IN (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  function automatic int model_ferr(logic [R-1:0] t, logic [R-1:0] e);
    for (int i = 0; i < R; i++)
      if (t[i] != e[i]) return i;
    return 0;
  endfunction

  function automatic int model_ones(logic [R-1:0] t);
    int n = 0;
    for (int i = 0; i < R; i++)
      n += int'(t[i]);
    return n;
  endfunction

  // Returns the number of edges after E0 until done (or rst edge), -1 on timeout.
  task automatic run_sweep(
    input  logic [R-1:0] tbl,
    input  logic [R-1:0] ex,
    input  int           ps,
    input  int           pr,
    output int           ed,
    output logic         b0,
    output logic         d0
  );
    fn_tbl = tbl;
    @(negedge clk);
    bus.expected = ex;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.expected = ~ex;
    b0 = bus.busy;
    d0 = bus.done;
    ed = -1;
    for (int e = 0; e < 100; e++) begin
      if (bus.done) begin
        ed = e;
        return;
      end
      if (e == ps - 1) bus.start = 1'b1;
      if (e == pr - 1) rst = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (e + 1 == pr) begin
        rst = 1'b0;
        ed = e + 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.expected = $urandom;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset busy/done got %b/%b want 0/0", bus.busy, bus.done);
    end
    tests++;
    if (bus.x !== '0 || bus.truth !== '0 || bus.ones !== '0) begin
      fails++;
      $display("FAIL reset x/truth/ones got %h/%h/%h want 0", bus.x, bus.truth, bus.ones);
    end
    tests++;
    if (bus.mismatch !== 1'b0 || bus.first_err !== '0) begin
      fails++;
      $display("FAIL reset mis/ferr got %b/%h want 0/0", bus.mismatch, bus.first_err);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.x !== '0) begin
      fails++;
      $display("FAIL idle_hold busy/done/x got %b/%b/%h want 0/0/0", bus.busy, bus.done, bus.x);
    end
  endtask

  task automatic check_sweep(
    input string        tag,
    input logic [R-1:0] tbl,
    input logic [R-1:0] ex,
    input int           ps
  );
    int   ed;
    logic b0;
    logic d0;
    run_sweep(tbl, ex, ps, -10, ed, b0, d0);
    tests++;
    if (ed !== 32) begin
      fails++;
      $display("FAIL %s done_edge got %0d want 32", tag, ed);
    end
    tests++;
    if (b0 !== 1'b1 || d0 !== 1'b0) begin
      fails++;
      $display("FAIL %s after_e0 busy/done got %b/%b want 1/0", tag, b0, d0);
    end
    tests++;
    if (bus.truth !== tbl) begin
      fails++;
      $display("FAIL %s truth got %h want %h", tag, bus.truth, tbl);
    end
    tests++;
    if (int'(bus.ones) !== model_ones(tbl)) begin
      fails++;
      $display("FAIL %s ones got %0d want %0d", tag, bus.ones, model_ones(tbl));
    end
    tests++;
    if (bus.mismatch !== (tbl != ex)) begin
      fails++;
      $display("FAIL %s mismatch got %b want %b", tag, bus.mismatch, tbl != ex);
    end
    tests++;
    if (int'(bus.first_err) !== model_ferr(tbl, ex)) begin
      fails++;
      $display("FAIL %s first_err got %0d want %0d", tag, bus.first_err, model_ferr(tbl, ex));
    end
    tests++;
    if (bus.busy !== 1'b0 || bus.x !== 5'd31) begin
      fails++;
      $display("FAIL %s end busy/x got %b/%0d want 0/31", tag, bus.busy, bus.x);
    end
  endtask

  task automatic test_patterns();
    logic [R-1:0] tb_t [4];
    logic [R-1:0] tb_e [4];
    tb_t = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'hFF00_0000};
    tb_e = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAB, 32'hFF00_0000};
    for (int i = 0; i < 4; i++)
      check_sweep($sformatf("pattern%0d", i), tb_t[i], tb_e[i], -10);
  endtask

  task automatic test_rearm();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.done !== 1'b1 || bus.truth !== 32'hFF00_0000) begin
      fails++;
      $display("FAIL rearm_hold done/truth got %b/%h want 1/ff000000", bus.done, bus.truth);
    end
    check_sweep("rearm", 32'hFF00_0000, 32'hFF00_0000, -10);
  endtask

  task automatic test_start_ignored();
    check_sweep("start_busy", 32'h1234_5678, 32'h1234_7678, 10);
  endtask

  task automatic test_rst_mid();
    int   ed;
    logic b0;
    logic d0;
    run_sweep(32'hDEAD_BEEF, 32'h0, -10, 15, ed, b0, d0);
    tests++;
    if (ed !== 15) begin
      fails++;
      $display("FAIL rst_mid edge got %0d want 15", ed);
    end
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.x !== '0) begin
      fails++;
      $display("FAIL rst_mid busy/done/x got %b/%b/%h want 0/0/0", bus.busy, bus.done, bus.x);
    end
    tests++;
    if (bus.truth !== '0 || bus.ones !== '0 || bus.mismatch !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid truth/ones/mis got %h/%0d/%b want 0", bus.truth, bus.ones, bus.mismatch);
    end
    check_sweep("after_rst", 32'h8000_0001, 32'h8000_0001, -10);
  endtask

  task automatic test_random();
    logic [R-1:0] t;
    logic [R-1:0] f;
    for (int i = 0; i < 12; i++) begin
      t = $urandom;
      case ($urandom_range(0, 2))
        0:       f = '0;
        1:       f = 32'h1 << $urandom_range(0, 31);
        default: f = $urandom & $urandom & $urandom;
      endcase
      check_sweep($sformatf("random%0d", i), t, t ^ f, -10);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_rearm();
    test_start_ignored();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
